mem_port_arbiter: RTL and testbench

Sequences a single shared memory port between instruction fetch and data load/store for the RISC-V core. Sits between the datapath and a unified instruction/data memory. Turns the core into a multi-cycle machine: the arbiter stalls the PC register and register-file write until the fetch and any data access have completed. It also counts retired instructions.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_timer.sv | 38 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: arbiter state encoding, the NOP substituted on a timed-out fetch,
//          and the default memory wait limit.
// Ports:   none (package).

package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - memory wait counter with clear/enable/expire
//
// Purpose: counts cycles spent waiting for mem_ack; flags expiry on the cycle
//          whose increment would make the count reach LIMIT.
// Ports:   clk, reset (async, active-low)
//          clear  - hold the count at zero (no request outstanding)
//          enable - a waiting cycle (request high, no ack)
//          expire - the wait limit is reached this cycle

module mem_arb_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Expire on the waiting cycle that completes the LIMIT-th wait, so the
  // access is abandoned at the same edge where the count would hit LIMIT.
  assign expire = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
//
// Purpose: multi-cycle sequencer IDLE -> FETCH -> EXEC -> (DATA -> WB) ->
//          FETCH; stalls the core until an instruction retires and counts
//          retired instructions. Optional timeout under MEM_ARB_TIMEOUT_EN.
// Ports:   clk, reset (async, active-low)
//          pc -> fetch address; instr/instr_valid -> fetched instruction
//          d_req/d_we/d_addr/d_wdata -> data access request; d_rdata -> load data
//          stall/commit/instret -> core control and retire count
//          mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata -> memory port
//          bus_err -> sticky timeout flag (0 without MEM_ARB_TIMEOUT_EN)

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          stall,
  output logic          commit,
  output logic [31:0]   instret,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t        state, state_nxt;
  logic          req_q, we_q, valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, instr_q, rdata_q;
  logic [31:0]   instret_q;
  logic          acked;
  logic          expired;
  logic          done;

  // An ack only counts against an outstanding request.
  assign acked = req_q & mem_ack;

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q;

  mem_arb_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (~req_q),
    .enable(req_q & ~mem_ack),
    .expire(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (expired) begin
      err_q <= 1'b1;
    end
  end

  assign bus_err = err_q;
`else
  assign expired = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign done = acked | expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (done) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (d_req) begin
          state_nxt = ST_DATA;
        end else begin
          commit    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_DATA:  if (done) state_nxt = ST_WB;
      ST_WB: begin
        commit    = 1'b1;
        state_nxt = ST_FETCH;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request flag, captured data access and result latches. req_q is set on
  // every edge that enters FETCH or DATA and cleared on the completing edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      instr_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      case (state)
        ST_IDLE: req_q <= 1'b1;
        ST_FETCH: begin
          if (done) begin
            req_q   <= 1'b0;
            instr_q <= acked ? mem_rdata : DW'(NOP_INSTR);
            valid_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          req_q <= 1'b1;
          if (d_req) begin
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
          end else begin
            valid_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (done) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (!acked)     rdata_q <= '0;
            else if (!we_q) rdata_q <= mem_rdata;
          end
        end
        ST_WB: begin
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        default: req_q <= 1'b0;
      endcase
      if (commit) instret_q <= instret_q + 32'd1;
    end
  end

  // The fetch address comes straight from the core's PC register, which is
  // frozen by stall for the whole FETCH; registering it here would capture
  // the pre-commit PC, since the PC only advances on the commit edge.
  assign mem_addr    = (state == ST_FETCH) ? pc : addr_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign d_rdata     = rdata_q;
  assign instret     = instret_q;
  assign stall       = ~commit;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        stall;
  logic        commit;
  logic [31:0] instret;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_instret = '0;
  logic [31:0] exp_drdata = '0;

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .stall      (stall),
    .commit     (commit),
    .instret    (instret),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One instruction from its first FETCH cycle to the first cycle of the next
  // FETCH. The memory acks w cycles after each request rises. Expected
  // latency: w+1 cycles to commit without a data access, 2w+3 with one.
  task automatic run_instr(input logic [31:0] a_pc, input logic [31:0] word, input int w,
                           input logic dreq, input logic dwe, input logic [31:0] daddr,
                           input logic [31:0] dwdata, input logic [31:0] drd, input logic spur);
    int   t0;
    logic ok;
    pc = a_pc;
    #1;
    t0 = cyc;
    check("fetch_req", {31'd0, mem_req}, 32'd1);
    ok = 1'b1;
    repeat (w) begin
      ok &= mem_req && !mem_we && (mem_addr == a_pc);
      step();
    end
    ok &= mem_req && !mem_we && (mem_addr == a_pc);
    check("fetch_stable", {31'd0, ok}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = word;
    d_req     = dreq;
    d_we      = dwe;
    d_addr    = daddr;
    d_wdata   = dwdata;
    step();
    mem_ack   = spur;
    mem_rdata = $urandom;
    check("instr", instr, word);
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    if (!dreq) begin
      check("commit_alu", {31'd0, commit}, 32'd1);
      check("stall_alu", {31'd0, stall}, 32'd0);
      check("lat_alu", cyc - t0, w + 1);
      exp_instret++;
      step();
      mem_ack = 1'b0;
      check("instret", instret, exp_instret);
      check("valid_clear", {31'd0, instr_valid}, 32'd0);
      check("instr_hold", instr, word);
      check("refetch_req", {31'd0, mem_req}, 32'd1);
    end else begin
      check("exec_stall", {31'd0, stall}, 32'd1);
      step();
      mem_ack = 1'b0;
      // Disturb the live inputs: the access must use the captured values.
      d_req   = 1'b0;
      d_we    = ~dwe;
      d_addr  = ~daddr;
      d_wdata = ~dwdata;
      ok = 1'b1;
      repeat (w) begin
        ok &= mem_req && (mem_we == dwe) && (mem_addr == daddr) && (!dwe || mem_wdata == dwdata);
        step();
      end
      ok &= mem_req && (mem_we == dwe) && (mem_addr == daddr) && (!dwe || mem_wdata == dwdata);
      check("data_stable", {31'd0, ok}, 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = drd;
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!dwe) exp_drdata = drd;
      check("commit_mem", {31'd0, commit}, 32'd1);
      check("lat_mem", cyc - t0, 2 * w + 3);
      check("d_rdata", d_rdata, exp_drdata);
      check("wb_req_low", {31'd0, mem_req}, 32'd0);
      exp_instret++;
      step();
      check("instret", instret, exp_instret);
      check("refetch_req", {31'd0, mem_req}, 32'd1);
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_instr($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(1, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    step();
    step();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_commit", {31'd0, commit}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd1);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_drdata", d_rdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    reset = 1'b1;
    check("idle_req", {31'd0, mem_req}, 32'd0);
    check("idle_stall", {31'd0, stall}, 32'd1);
    step();

    run_instr(32'h0, 32'h0050_0093, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    run_instr(32'h4, 32'h0001_2083, 3, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run_instr(32'h8, 32'h0020_2223, 2, 1'b1, 1'b1, 32'h104, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);
    run_instr(32'hC, 32'h0010_8093, 2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_random(30);

    // Asynchronous reset while a load waits in DATA.
    pc = 32'h200;
    #1;
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0013;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h300;
    step();
    mem_ack = 1'b0;
    step();
    check("pre_rst_data_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_req_drop", {31'd0, mem_req}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    d_req   = 1'b0;
    reset   = 1'b1;
    exp_instret = '0;
    exp_drdata  = '0;
    check("arst_idle_req", {31'd0, mem_req}, 32'd0);
    check("arst_instret", instret, 32'd0);
    check("arst_drdata", d_rdata, 32'd0);
    step();
    run_random(15);

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int t0;
      pc = 32'h400;
      #1;
      t0 = cyc;
      d_req = 1'b0;
      repeat (3) step();
      check("to_no_commit", {31'd0, commit}, 32'd0);
      check("to_err_early", {31'd0, bus_err}, 32'd0);
      step();
      check("to_commit", {31'd0, commit}, 32'd1);
      check("to_lat", cyc - t0, 32'd4);
      check("to_bus_err", {31'd0, bus_err}, 32'd1);
      check("to_nop", instr, NOP);
      exp_instret++;
      step();
      check("to_instret", instret, exp_instret);
      run_random(3);
      check("to_err_sticky", {31'd0, bus_err}, 32'd1);
    end
`else
    check("bus_err_off", {31'd0, bus_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
